demux_stream_1_n: RTL and testbench
===================================

DEMUX_STREAM_1_N -- requirements
Module: demux_stream_1_n

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 The module SHALL have parameter N_CH, default 4, number of output channels (2..16).
REQ-003 The module SHALL have parameter SEL_W, default 2, select width; SEL_W SHALL equal ceil(log2(N_CH)).
REQ-004 The module SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The module SHALL have port i_valid, input, 1 bit: upstream word present.
REQ-007 The module SHALL have port o_ready, output, 1 bit: the module accepts the word this cycle.
REQ-008 The module SHALL have port i_data, input, DATA_W bits: the payload.
REQ-009 The module SHALL have port i_sel_code, input, SEL_W bits: the target channel in addressed mode.
REQ-010 The module SHALL have port i_mode, input, 2 bits: 00 addressed, 01 broadcast, 10 round-robin, 11 addressed.
REQ-011 The module SHALL have port o_valid, output, N_CH bits: per-channel output word present.
REQ-012 The module SHALL have port i_ready, input, N_CH bits: per-channel downstream ready.
REQ-013 The module SHALL have port o_data, output, N_CH*DATA_W bits: channel c at bits [c*DATA_W +: DATA_W].
REQ-014 The module SHALL have port o_rr_ptr, output, SEL_W bits: the next round-robin target.
REQ-015 The module SHALL have port o_err, output, 1 bit: sticky out-of-range select flag.

Function
REQ-016 Each channel SHALL hold one output word (valid bit plus data register); no other buffering.
REQ-017 Target set T SHALL be: addressed = {i_sel_code}; broadcast = all channels; round-robin = {o_rr_ptr}.
REQ-018 Channel c can accept when o_valid[c]==0 or i_ready[c]==1.
REQ-019 o_ready SHALL be the AND of can-accept over all c in T, combinational from i_ready, o_valid, i_mode, i_sel_code and o_rr_ptr.
REQ-020 A transfer SHALL occur when i_valid && o_ready at a rising edge; every c in T SHALL load i_data with o_valid[c]=1 on the next cycle (latency 1).
REQ-021 Broadcast SHALL be all-or-nothing: no channel loads unless every channel can accept.
REQ-022 A channel with o_valid=1 and i_ready=1 that is not loaded SHALL clear o_valid the next cycle.
REQ-023 On a simultaneous drain and load of the same channel, the load SHALL win: o_valid stays 1 and the new data appears.
REQ-024 While o_valid[c]==1 and i_ready[c]==0, o_data for channel c SHALL be held stable.
REQ-025 o_data for a channel that is not loaded SHALL retain its last value.
REQ-026 In addressed mode with i_sel_code >= N_CH: o_ready SHALL be 1, a transfer SHALL load no channel, and o_err SHALL set to 1.
REQ-027 o_err SHALL be cleared only by reset.
REQ-028 o_rr_ptr SHALL increment on each transfer in round-robin mode, wrapping from N_CH-1 to 0, and SHALL hold otherwise, including on a mode change.
REQ-029 i_valid=0 SHALL cause no load, no o_rr_ptr change and no o_err change.

Reset
REQ-030 Asserting i_rst_n=0 SHALL immediately force o_valid=0, all o_data=0, o_rr_ptr=0 and o_err=0, regardless of the clock.
REQ-031 Reset mid-operation SHALL discard all held words; no transfer SHALL occur while i_rst_n=0.
REQ-032 After release, the first transfer SHALL be accepted on the first rising edge with i_rst_n=1.

Verification
REQ-033 Addressed: N_CH=4, i_ready=1111, i_mode=00, sel=2, data=8'hA5 for one cycle -> next cycle o_valid=0100, channel 2 = A5; the following cycle o_valid=0000.
REQ-034 Backpressure: i_ready[1]=0, send 8'h11 then 8'h22 to sel=1 -> o_ready=0 on the second word, channel 1 holds 11; raising i_ready[1] -> 11 drains and 22 loads the same edge.
REQ-035 Broadcast: i_ready=1011, channel 2 holding a word, i_mode=01 -> o_ready=0 and no channel loads; i_ready=1111 -> all four load the word next cycle.
REQ-036 Round-robin: i_mode=10, 6 words 0..5 with all ready -> targets 0,1,2,3,0,1 and o_rr_ptr=2 at the end.
REQ-037 Out-of-range: N_CH=3, sel=3, i_valid=1 -> o_ready=1, o_valid unchanged, o_err=1 and sticky until i_rst_n pulses low.
REQ-038 Async reset: drop i_rst_n mid-cycle with o_valid=1111 -> outputs zero before the next clock edge.

Source files
------------

// File: rtl/demux_stream_1_n.sv
// One-to-N stream demultiplexer: each input word goes to one channel, all
// channels, or the next round-robin channel; each output holds one word.
module demux_stream_1_n #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_W-1:0]        i_data,
    input  logic [SEL_W-1:0]         i_sel_code,
    input  logic [1:0]               i_mode,
    output logic [N_CH-1:0]          o_valid,
    input  logic [N_CH-1:0]          i_ready,
    output logic [N_CH*DATA_W-1:0]   o_data,
    output logic [SEL_W-1:0]         o_rr_ptr,
    output logic                     o_err
);

    localparam logic [1:0]       MODE_BCAST = 2'b01;
    localparam logic [1:0]       MODE_RR    = 2'b10;
    localparam logic [SEL_W:0]   N_CH_X     = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] RR_LAST    = SEL_W'(N_CH - 1);

    logic [N_CH-1:0]        valid_q;
    logic [N_CH*DATA_W-1:0] data_q;
    logic [SEL_W-1:0]       rr_q;
    logic                   err_q;

    logic [N_CH-1:0] can_acc;
    logic [N_CH-1:0] tmask;
    logic [N_CH-1:0] load;
    logic            addressed;
    logic            sel_ok;
    logic            xfer;

    // Handshake: upstream word moves when i_valid && o_ready at a rising edge;
    // channel c drains when o_valid[c] && i_ready[c] at a rising edge.
    // o_ready is the AND of can-accept over the target set, so a broadcast is
    // all-or-nothing and an empty target set (bad select) always accepts.
    always_comb begin
        addressed = (i_mode != MODE_BCAST) && (i_mode != MODE_RR);
        sel_ok    = ({1'b0, i_sel_code} < N_CH_X);
        can_acc   = ~valid_q | i_ready;
        tmask     = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_mode == MODE_BCAST)
                tmask[c] = 1'b1;
            else if (i_mode == MODE_RR)
                tmask[c] = (rr_q == SEL_W'(c));
            else
                tmask[c] = sel_ok && (i_sel_code == SEL_W'(c));
        end
        o_ready = &(can_acc | ~tmask);
        xfer    = i_valid && o_ready;
        load    = tmask & {N_CH{xfer}};
    end

    // A load on the same edge as a drain wins: the slot stays valid with new data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (load[c]) begin
                    valid_q[c]                  <= 1'b1;
                    data_q[c*DATA_W +: DATA_W]  <= i_data;
                end else if (i_ready[c]) begin
                    valid_q[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q <= '0;
        end else if (xfer && (i_mode == MODE_RR)) begin
            rr_q <= (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
        end
    end

    // Sticky until reset: records any accepted word whose select had no channel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (xfer && addressed && !sel_ok) begin
            err_q <= 1'b1;
        end
    end

    assign o_valid  = valid_q;
    assign o_data   = data_q;
    assign o_rr_ptr = rr_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_demux_stream_1_n.sv
// Bench for demux_stream_1_n: scoreboarded 4-channel instance plus a
// 3-channel instance for out-of-range select handling.
module tb_demux_stream_1_n;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic [1:0]  i_sel_code;
    logic [1:0]  i_mode;
    logic [3:0]  o_valid;
    logic [3:0]  i_ready;
    logic [31:0] o_data;
    logic [1:0]  o_rr_ptr;
    logic        o_err;

    logic        b_valid;
    logic        b_o_ready;
    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic [1:0]  b_mode;
    logic [2:0]  b_o_valid;
    logic [2:0]  b_ready;
    logic [23:0] b_o_data;
    logic [1:0]  b_rr;
    logic        b_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[4][$];
    logic [1:0] model_rr = 2'd0;

    demux_stream_1_n #(.DATA_W(8), .N_CH(4), .SEL_W(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_sel_code(i_sel_code), .i_mode(i_mode),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_rr_ptr(o_rr_ptr), .o_err(o_err)
    );

    demux_stream_1_n #(.DATA_W(8), .N_CH(3), .SEL_W(2)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(b_valid), .o_ready(b_o_ready),
        .i_data(b_data), .i_sel_code(b_sel), .i_mode(b_mode),
        .o_valid(b_o_valid), .i_ready(b_ready), .o_data(b_o_data),
        .o_rr_ptr(b_rr), .o_err(b_err)
    );

    // clock / watchdog
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one word and wait for acceptance; expectations are pushed on the
    // accepting edge. Must be called in the posedge+1 phase.
    task automatic send(input logic [1:0] mode, input logic [1:0] sel, input logic [7:0] data,
                        input bit rand_ready, output int waited);
        bit done;
        done       = 1'b0;
        waited     = 0;
        i_valid    = 1'b1;
        i_mode     = mode;
        i_sel_code = sel;
        i_data     = data;
        while (!done) begin
            @(negedge i_clk);
            if (o_ready) begin
                @(posedge i_clk);
                for (int c = 0; c < 4; c++) begin
                    if (mode == 2'b01 || (mode == 2'b10 && model_rr == 2'(c)) ||
                        ((mode == 2'b00 || mode == 2'b11) && sel == 2'(c)))
                        exp_q[c].push_back(data);
                end
                if (mode == 2'b10) model_rr = model_rr + 2'd1;
                #1;
                done = 1'b1;
            end else begin
                waited++;
                if (waited >= 50) begin
                    chk("send_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end else begin
                    @(posedge i_clk);
                    #1;
                    if (rand_ready) i_ready = 4'($urandom_range(0, 15));
                end
            end
        end
        i_valid = 1'b0;
    endtask

    // scoreboard: a word leaves channel c at the edge after a negedge that sees valid&&ready
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            for (int c = 0; c < 4; c++) begin
                if (o_valid[c] && i_ready[c]) begin
                    if (exp_q[c].size() == 0)
                        chk($sformatf("unexpected_ch%0d", c), 32'(o_data[c*8 +: 8]), 32'hxxxx_xxxx);
                    else
                        chk($sformatf("data_ch%0d", c), 32'(o_data[c*8 +: 8]), 32'(exp_q[c].pop_front()));
                end
            end
        end
    end

    initial begin
        int w;
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_sel_code = '0; i_mode = '0; i_ready = '0;
        b_valid = 1'b0; b_data = '0; b_sel = '0; b_mode = '0; b_ready = 3'b111;
        #1;
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_rr", 32'(o_rr_ptr), 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // addressed single word
        i_ready = 4'b1111;
        send(2'b00, 2'd2, 8'hA5, 1'b0, w);
        @(negedge i_clk);
        chk("addr_valid", 32'(o_valid), 32'b0100);
        chk("addr_data", 32'(o_data[23:16]), 32'hA5);
        step();
        @(negedge i_clk);
        chk("addr_drained", 32'(o_valid), 32'b0000);
        step();

        // backpressure on channel 1, then drain and load on the same edge
        i_ready = 4'b1101;
        send(2'b00, 2'd1, 8'h11, 1'b0, w);
        i_valid = 1'b1; i_sel_code = 2'd1; i_data = 8'h22;
        @(negedge i_clk);
        chk("bp_ready_low", 32'(o_ready), 32'h0);
        chk("bp_hold", 32'(o_data[15:8]), 32'h11);
        step();
        @(negedge i_clk);
        chk("bp_hold2", 32'(o_data[15:8]), 32'h11);
        step();
        i_ready = 4'b1111;
        send(2'b00, 2'd1, 8'h22, 1'b0, w);
        @(negedge i_clk);
        chk("bp_swap_valid", 32'(o_valid), 32'b0010);
        chk("bp_swap_data", 32'(o_data[15:8]), 32'h22);
        step();

        // broadcast all-or-nothing
        i_ready = 4'b1011;
        send(2'b00, 2'd2, 8'h33, 1'b0, w);
        i_valid = 1'b1; i_mode = 2'b01; i_data = 8'h44;
        @(negedge i_clk);
        chk("bc_ready_low", 32'(o_ready), 32'h0);
        step();
        @(negedge i_clk);
        chk("bc_no_load", 32'(o_valid), 32'b0100);
        chk("bc_hold", 32'(o_data[23:16]), 32'h33);
        step();
        i_ready = 4'b1111;
        send(2'b01, 2'd0, 8'h44, 1'b0, w);
        @(negedge i_clk);
        chk("bc_all_valid", 32'(o_valid), 32'b1111);
        chk("bc_all_data", o_data, 32'h4444_4444);
        step();

        // round-robin 0..5
        for (int k = 0; k < 6; k++) begin
            send(2'b10, 2'd0, 8'(k), 1'b0, w);
            @(negedge i_clk);
            chk($sformatf("rr_target_%0d", k), 32'(o_valid), 32'(1 << (k % 4)));
            step();
        end
        chk("rr_ptr_end", 32'(o_rr_ptr), 32'd2);

        // random traffic with random backpressure
        for (int k = 0; k < 60; k++) begin
            i_ready = 4'($urandom_range(0, 15));
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 1'b1, w);
            chk("rand_rr", 32'(o_rr_ptr), 32'(model_rr));
        end
        i_ready = 4'b1111;
        repeat (3) step();
        for (int c = 0; c < 4; c++) chk($sformatf("drain_ch%0d", c), exp_q[c].size(), 32'd0);
        chk("err_clean", 32'(o_err), 32'h0);

        // out-of-range select on the 3-channel instance
        b_ready = 3'b110; b_sel = 2'd3; b_mode = 2'b00;
        @(negedge i_clk);
        chk("oor_ready", 32'(b_o_ready), 32'h1);
        step();
        @(negedge i_clk);
        chk("oor_idle_err", 32'(b_err), 32'h0);
        step();
        b_sel = 2'd0; b_data = 8'h5A; b_valid = 1'b1;
        step();
        b_sel = 2'd3; b_data = 8'hEE;
        @(negedge i_clk);
        chk("oor_ready_busy", 32'(b_o_ready), 32'h1);
        step();
        b_valid = 1'b0;
        @(negedge i_clk);
        chk("oor_valid", 32'(b_o_valid), 32'b001);
        chk("oor_data", 32'(b_o_data[7:0]), 32'h5A);
        chk("oor_err", 32'(b_err), 32'h1);
        repeat (5) step();
        chk("oor_sticky", 32'(b_err), 32'h1);

        // asynchronous reset mid-cycle with all channels full
        i_ready = 4'b0000;
        send(2'b01, 2'd0, 8'hC3, 1'b0, w);
        @(negedge i_clk);
        chk("pre_rst_valid", 32'(o_valid), 32'b1111);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'h0);
        chk("arst_data", o_data, 32'h0);
        chk("arst_rr", 32'(o_rr_ptr), 32'h0);
        chk("arst_b_err", 32'(b_err), 32'h0);
        chk("arst_b_valid", 32'(b_o_valid), 32'h0);
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        model_rr = 2'd0;
        i_ready = 4'b1111; i_valid = 1'b1; i_mode = 2'b00; i_sel_code = 2'd0; i_data = 8'h99;
        step();
        chk("rst_no_xfer", 32'(o_valid), 32'h0);
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        send(2'b00, 2'd3, 8'h7E, 1'b0, w);
        chk("post_rst_wait", 32'(w), 32'd0);
        @(negedge i_clk);
        chk("post_rst_valid", 32'(o_valid), 32'b1000);
        step();
        repeat (2) step();
        for (int c = 0; c < 4; c++) chk($sformatf("final_q%0d", c), exp_q[c].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
